// File: rtl/jk_ff_pkg.sv
// Shared JK action encodings for the jk_ff slice and its users.
// The action code is the concatenation {j, k}.
package jk_ff_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_action_e;

endpackage

// File: rtl/jk_ff_bit.sv
// Single JK bit-slice: one state register with an asynchronous active-high reset.
// qbar is an inversion of the same register, so q and qbar can never agree.
module jk_ff_bit
  import jk_ff_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  logic q_reg;
  logic q_next;

  always_comb begin
    q_next = q_reg;
    case ({j, k})
      JK_HOLD: q_next = q_reg;
      JK_CLR:  q_next = 1'b0;
      JK_SET:  q_next = 1'b1;
      JK_TGL:  q_next = ~q_reg;
      default: q_next = 1'bx;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= RESET_VAL;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q    = q_reg;
  assign qbar = ~q_reg;

endmodule

// File: rtl/jk_ff.sv
// WIDTH independent JK flip-flops sharing one clock and one asynchronous reset.
// The top only fans out clk/rst and gathers the per-slice q/qbar bits.
module jk_ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
      jk_ff_bit #(
        .RESET_VAL(RESET_VAL[gi])
      ) u_bit (
        .clk (clk),
        .rst (rst),
        .j   (j[gi]),
        .k   (k[gi]),
        .q   (q[gi]),
        .qbar(qbar[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_jk_ff.sv
// Scoreboard bench for jk_ff: a 4-bit instance (reset to 0) and a 1-bit instance (reset to 1)
// share clk/rst; expected states come from the JK characteristic equation.
module tb_jk_ff;

  localparam logic [3:0] R4 = 4'b0000;
  localparam logic       R1 = 1'b1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] j   = '0;
  logic [3:0] k   = '0;
  logic [3:0] q4, qb4;
  logic [0:0] q1, qb1;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  logic [4:0] sb_q[$];
  logic [3:0] m4;
  logic       m1;
  bit         stim_done = 1'b0;

  jk_ff #(.WIDTH(4), .RESET_VAL(R4)) dut4 (
    .clk (clk),
    .rst (rst),
    .j   (j),
    .k   (k),
    .q   (q4),
    .qbar(qb4)
  );

  jk_ff #(.WIDTH(1), .RESET_VAL(R1)) dut1 (
    .clk (clk),
    .rst (rst),
    .j   (j[0:0]),
    .k   (k[0:0]),
    .q   (q1),
    .qbar(qb1)
  );

  always #5 clk = ~clk;

  // Applies inputs mid-cycle and records what both DUTs must show afterwards.
  task automatic step(input logic rv, input logic [3:0] jv, input logic [3:0] kv);
    if (rv && !rst) begin
      sb_q.push_back({R4, R1});
    end
    rst = rv;
    j   = jv;
    k   = kv;
    if (rv) begin
      m4 = R4;
      m1 = R1;
    end else begin
      m4 = (jv & ~m4) | (~kv & m4);
      m1 = (jv[0] & ~m1) | (~kv[0] & m1);
    end
    sb_q.push_back({m4, m1});
    @(posedge clk);
    #7;
  endtask

  // Monitor: every clk rise or rst rise presents a new output to check.
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL underflow: output seen at %0t but no expected entry", $time);
      end else begin
        e = sb_q.pop_front();
        txn++;
        $display("txn %0d t=%0t rst=%b j=%b k=%b q4=%b q1=%b", txn, $time, rst, j, k, q4, q1);
        if (q4 !== e[4:1] || qb4 !== ~e[4:1]) begin
          bad++;
          $display("FAIL q4 t=%0t: got q=%b qbar=%b, want q=%b qbar=%b", $time, q4, qb4, e[4:1], ~e[4:1]);
        end
        total++;
        if (q1[0] !== e[0] || qb1[0] !== ~e[0]) begin
          bad++;
          $display("FAIL q1 t=%0t: got q=%b qbar=%b, want q=%b qbar=%b", $time, q1, qb1, e[0], ~e[0]);
        end
      end
    end
  end

  // Complement check between edges, independent of the scoreboard.
  always @(negedge clk) begin
    total++;
    if (qb4 !== ~q4 || qb1 !== ~q1) begin
      bad++;
      $display("FAIL qbar_compl t=%0t: got qbar4=%b qbar1=%b, want %b %b", $time, qb4, qb1, ~q4, ~q1);
    end
  end

  initial begin
    m4 = R4;
    m1 = R1;
    #1;
    // Reset from time 0 plus the t=5 edge held in reset.
    sb_q.push_back({R4, R1});
    rst = 1'b1;
    sb_q.push_back({R4, R1});
    #11;
    step(1'b0, 4'hF, 4'h0);  // set
    step(1'b0, 4'h0, 4'hF);  // clear
    step(1'b0, 4'hF, 4'hF);  // toggle -> 1
    step(1'b0, 4'hF, 4'hF);  // toggle -> 0
    step(1'b0, 4'hF, 4'hF);  // toggle -> 1
    repeat (3) step(1'b0, 4'h0, 4'h0);
    step(1'b1, 4'hF, 4'hF);  // async reset while q=1
    step(1'b1, 4'hF, 4'hF);
    step(1'b0, 4'b0011, 4'b1100);
    step(1'b0, 4'b1010, 4'b0110);  // 0011 -> 1001
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 15) == 0), 4'($urandom), 4'($urandom));
    end
    step(1'b0, 4'h0, 4'h0);
    stim_done = 1'b1;
  end

  initial begin
    fork
      wait (stim_done);
      #100000;
    join_any
    #3;
    total++;
    if (!stim_done || sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: done=%0d pending=%0d, want done=1 pending=0", stim_done, sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
